gpio_debounce_ctrl: RTL and testbench

GPIO_DEBOUNCE_CTRL -- requirements
Module: gpio_debounce_ctrl

---
 rtl/gpio_debounce_ctrl_if.sv | 23 ++
 rtl/gpio_debounce_ctrl.sv | 127 ++++++++++++
 tb/tb_gpio_debounce_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gpio_debounce_ctrl_if.sv
// Register-bus and interrupt signals between a host and gpio_debounce_ctrl.
// The master drives strobes and write data; the slave returns read data, rvalid and irq.
interface gpio_debounce_ctrl_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [2:0]       bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic             bus_we;
    logic             bus_re;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_rvalid;
    logic             irq;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_rvalid, irq
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_rvalid, irq
    );
endinterface

// File: rtl/gpio_debounce_ctrl.sv
// GPIO block with per-pin direction control, synchronised and debounced inputs,
// edge-selectable interrupt status (W1C), and a one-cycle-latency register bus.
module gpio_debounce_ctrl #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    inout  wire  [WIDTH-1:0]     gpio,
    gpio_debounce_ctrl_if.slave  bus
);
    localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
    localparam logic [2:0] ADDR_DIR        = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd4;
    localparam logic [2:0] ADDR_EDGE_SEL   = 3'd5;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] irq_status_q;
    logic [WIDTH-1:0] edge_sel_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             irq_q;

    logic [WIDTH-1:0] rdata_c;
    logic [WIDTH-1:0] w1c_c;
    logic [WIDTH-1:0] edge_set_c;
    logic [WIDTH-1:0] irq_status_c;

    // Pin drivers: output-enabled pins carry DATA_OUT, the rest float
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
        assign gpio[i] = dir_q[i] ? data_out_q[i] : 1'bz;
    end

    // Edge detection on the debounced level, delayed one cycle; a new set beats a same-cycle W1C
    always_comb begin
        w1c_c        = '0;
        edge_set_c   = '0;
        irq_status_c = irq_status_q;
        if (bus.bus_we && bus.bus_addr == ADDR_IRQ_STATUS) begin
            w1c_c = bus.bus_wdata;
        end
        edge_set_c   = (stable_q & ~stable_d_q & ~edge_sel_q)
                     | (~stable_q & stable_d_q & edge_sel_q);
        irq_status_c = (irq_status_q & ~w1c_c) | edge_set_c;
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rdata_c = '0;
        case (bus.bus_addr)
            ADDR_DATA_OUT:   rdata_c = data_out_q;
            ADDR_DIR:        rdata_c = dir_q;
            ADDR_DATA_IN:    rdata_c = stable_q;
            ADDR_IRQ_EN:     rdata_c = irq_en_q;
            ADDR_IRQ_STATUS: rdata_c = irq_status_q;
            ADDR_EDGE_SEL:   rdata_c = edge_sel_q;
            default:         rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_status_q <= '0;
            edge_sel_q   <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_d_q   <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            irq_q        <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= gpio;
            sync2_q      <= sync1_q;
            stable_d_q   <= stable_q;
            irq_status_q <= irq_status_c;
            irq_q        <= |(irq_status_q & irq_en_q);
            rvalid_q     <= bus.bus_re;
            if (bus.bus_re) begin
                rdata_q <= rdata_c;
            end

            if (bus.bus_we) begin
                case (bus.bus_addr)
                    ADDR_DATA_OUT: data_out_q <= bus.bus_wdata;
                    ADDR_DIR:      dir_q      <= bus.bus_wdata;
                    ADDR_IRQ_EN:   irq_en_q   <= bus.bus_wdata;
                    ADDR_EDGE_SEL: edge_sel_q <= bus.bus_wdata;
                    default:       ;
                endcase
            end

            // Per-pin debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
    assign bus.irq        = irq_q;
endmodule

// File: tb/tb_gpio_debounce_ctrl.sv
// Directed bench for gpio_debounce_ctrl: reads push expectations into a scoreboard
// that a negedge monitor drains whenever bus_rvalid is seen.
module tb_gpio_debounce_ctrl;
    localparam int unsigned W  = 16;
    localparam int unsigned DB = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    wire  [W-1:0] gpio;
    logic [W-1:0] tb_oe;
    logic [W-1:0] tb_val;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q  [$];
    logic [2:0]   addr_q [$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < int'(W); i++) begin : g_drv
        assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    gpio_debounce_ctrl_if #(.WIDTH(W)) bus ();

    gpio_debounce_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .gpio(gpio),
        .bus(bus)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rvalid must match the oldest outstanding read
    always @(negedge clk) begin
        if (bus.bus_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata 0x%0h, expected no response at %0t",
                         bus.bus_rdata, $time);
            end else begin
                logic [W-1:0] e;
                logic [2:0]   a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                check($sformatf("rdata_addr%0d", a), bus.bus_rdata, e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_we    = 1'b1;
        step(1);
        bus.bus_we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] e);
        bus.bus_addr = a;
        bus.bus_re   = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
        step(1);
        bus.bus_re   = 1'b0;
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [W-1:0] d, input logic [W-1:0] e);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_we    = 1'b1;
        bus.bus_re    = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
        step(1);
        bus.bus_we    = 1'b0;
        bus.bus_re    = 1'b0;
    endtask

    initial begin
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_we    = 1'b0;
        bus.bus_re    = 1'b0;
        tb_oe         = '1;
        tb_val        = '0;
        reset_n       = 1'b0;
        step(3);
        check("reset_irq", W'(bus.irq), '0);
        check("reset_rvalid", W'(bus.bus_rvalid), '0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(3'(a), '0);

        // Pin 0 as output, looped back through sync + debounce
        tb_oe[0] = 1'b0;
        wr(3'd1, 16'h0001);
        wr(3'd0, 16'h0001);
        check("gpio0_driven", W'(gpio[0]), 16'h0001);
        step(7);
        rd(3'd2, 16'h0001);
        rd(3'd1, 16'h0001);
        rd(3'd0, 16'h0001);
        wr(3'd0, 16'h0000);
        step(10);
        rd(3'd2, 16'h0000);
        wr(3'd4, 16'hFFFF);
        rd(3'd4, 16'h0000);

        // Glitch of 3 cycles is rejected; 4 cycles is accepted
        tb_val[3] = 1'b1;
        step(3);
        tb_val[3] = 1'b0;
        step(10);
        rd(3'd2, 16'h0000);
        rd(3'd4, 16'h0000);
        tb_val[9] = 1'b1;
        step(4);
        tb_val[9] = 1'b0;
        step(12);
        rd(3'd4, 16'h0200);
        rd(3'd2, 16'h0000);
        wr(3'd4, 16'h0200);
        rd(3'd4, 16'h0000);

        // Enabled interrupt on pin 3: exact set and clear timing
        wr(3'd3, 16'h0008);
        tb_val[3] = 1'b1;
        step(7);
        check("irq_lags_status", W'(bus.irq), '0);
        step(1);
        check("irq_set", W'(bus.irq), 16'h0001);
        rd(3'd4, 16'h0008);
        wr(3'd4, 16'h0000);
        check("irq_w1c_zero_no_effect", W'(bus.irq), 16'h0001);
        wr(3'd4, 16'h0008);
        check("irq_clear_lag", W'(bus.irq), 16'h0001);
        step(1);
        check("irq_cleared", W'(bus.irq), '0);

        // Falling-edge selection on pin 5
        wr(3'd5, 16'h0020);
        tb_val[5] = 1'b1;
        step(10);
        rd(3'd4, 16'h0000);
        tb_val[5] = 1'b0;
        step(10);
        rd(3'd4, 16'h0020);
        wr(3'd4, 16'h0020);

        // W1C lands on the same edge that sets bit 2: set wins
        tb_val[2] = 1'b1;
        step(6);
        wr(3'd4, 16'h0004);
        rd(3'd4, 16'h0004);
        wr(3'd4, 16'h0004);
        rd(3'd4, 16'h0000);

        // Same-cycle read/write returns the old value; addresses 6-7 are inert
        rdwr(3'd0, 16'h00A4, 16'h0000);
        rd(3'd0, 16'h00A4);
        rdwr(3'd6, 16'hFFFF, 16'h0000);
        rd(3'd6, 16'h0000);
        rd(3'd7, 16'h0000);
        rd(3'd3, 16'h0008);
        rd(3'd5, 16'h0020);

        // Reset mid-debounce of pin 7 and mid-read
        tb_val = '0;
        step(10);
        rd(3'd4, 16'h0000);
        tb_val[7] = 1'b1;
        step(4);
        reset_n      = 1'b0;
        bus.bus_addr = 3'd4;
        bus.bus_re   = 1'b1;
        step(1);
        reset_n    = 1'b1;
        bus.bus_re = 1'b0;
        tb_oe[0]   = 1'b1;
        check("post_reset_irq", W'(bus.irq), '0);
        check("post_reset_rvalid", W'(bus.bus_rvalid), '0);
        rd(3'd4, 16'h0000);
        rd(3'd2, 16'h0000);
        rd(3'd0, 16'h0000);
        rd(3'd1, 16'h0000);
        rd(3'd3, 16'h0000);
        rd(3'd5, 16'h0000);
        step(10);
        rd(3'd4, 16'h0080);
        rd(3'd2, 16'h0080);
        check("post_reset_irq_disabled", W'(bus.irq), '0);

        step(3);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_rvalid: got %0d outstanding reads, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
